mesm6_alu_seq: RTL and testbench



---
 rtl/mesm6_alu_seq.sv | 125 ++++++++++++
 tb/tb_mesm6_alu_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mesm6_alu_seq.sv
// rtl/mesm6_alu_seq.sv - ALU op/done handshake initiator with accumulator/Y capture and timeout abort
// Issues one ALU op per command, captures result on done, forces NOP for a cycle, then responds.
module mesm6_alu_seq #(
   parameter int                   OP_WIDTH = 5,
   parameter logic [OP_WIDTH-1:0]  OP_NOP   = '0,
   parameter int                   TIMEOUT  = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [OP_WIDTH-1:0] cmd_op,
   input  logic [47:0]         cmd_a,
   input  logic [47:0]         cmd_b,
   output logic [OP_WIDTH-1:0] alu_op,
   output logic [47:0]         alu_a,
   output logic [47:0]         alu_b,
   input  logic [47:0]         alu_result,
   input  logic [47:0]         alu_y,
   input  logic                alu_done,
   output logic [47:0]         acc,
   output logic [47:0]         y,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_error,
   output logic                busy
);

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE, S_RESP} state_t;

   state_t              state_q, state_d;
   logic [OP_WIDTH-1:0] op_q, op_d;
   logic [47:0]         a_q, a_d;
   logic [47:0]         b_q, b_d;
   logic [47:0]         acc_q, acc_d;
   logic [47:0]         y_q, y_d;
   logic                err_q, err_d;
   logic [7:0]          cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= OP_NOP;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         y_q     <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         y_q     <= y_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      y_d     = y_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d = cmd_op;
               a_d  = cmd_a;
               b_d  = cmd_b;
               if (cmd_op != OP_NOP) begin
                  state_d = S_ISSUE;
                  cnt_d   = '0;
               end else begin
                  state_d = S_RESP;
                  err_d   = 1'b0;
               end
            end
         end
         S_ISSUE: begin
            cnt_d = cnt_q + 8'd1;
            // cnt_q == 0 marks the first ISSUE cycle, where done is still left over from the last op
            if ((cnt_q != 8'd0) && alu_done) begin
               acc_d   = alu_result;
               y_d     = alu_y;
               err_d   = 1'b0;
               state_d = S_RELEASE;
            end else if (cnt_d == TIMEOUT_C) begin
               err_d   = 1'b1;
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            state_d = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign alu_op    = (state_q == S_ISSUE) ? op_q : OP_NOP;
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign acc       = acc_q;
   assign y         = y_q;
   assign cmd_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_error = err_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mesm6_alu_seq.sv
// tb/tb_mesm6_alu_seq.sv - directed bench for mesm6_alu_seq with a behavioural multi-cycle ALU
// The ALU model can hang (done stuck low) or be overridden by hand-driven done/result.
module tb_mesm6_alu_seq;

   localparam logic [4:0] OP_NOP = 5'd0;
   localparam logic [4:0] OP_AND = 5'd1;
   localparam logic [4:0] OP_XOR = 5'd2;
   localparam logic [4:0] OP_ARX = 5'd3;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [4:0]  cmd_op;
   logic [47:0] cmd_a, cmd_b;
   logic [4:0]  alu_op;
   logic [47:0] alu_a, alu_b;
   logic [47:0] alu_result, alu_y;
   logic        alu_done;
   logic [47:0] acc, y;
   logic        rsp_valid, rsp_ready, rsp_error, busy;

   logic        hang   = 1'b0;
   logic        manual = 1'b0;
   logic        m_done = 1'b0;
   logic [47:0] m_result = '0, m_y = '0;
   logic        md_q = 1'b0;
   logic [47:0] mr_q = '0, my_q = '0;
   logic [1:0]  mc_q = '0;
   logic [48:0] sum;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   mesm6_alu_seq #(.OP_WIDTH(5), .OP_NOP(5'd0), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_y(alu_y), .alu_done(alu_done),
      .acc(acc), .y(y),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_error(rsp_error),
      .busy(busy)
   );

   // Behavioural ALU: AND/XOR take 1 cycle, ARX 2; done holds until op returns to NOP
   always @(posedge clk) begin
      if (alu_op == OP_NOP) begin
         md_q <= 1'b0;
         mc_q <= '0;
      end else if (!md_q) begin
         mc_q <= mc_q + 2'd1;
         if (mc_q + 2'd1 == ((alu_op == OP_ARX) ? 2'd2 : 2'd1)) begin
            md_q <= 1'b1;
            sum   = {1'b0, alu_a} + {1'b0, alu_b};
            case (alu_op)
               OP_AND:  begin mr_q <= alu_a & alu_b; my_q <= '0; end
               OP_XOR:  begin mr_q <= alu_a ^ alu_b; my_q <= alu_a; end
               OP_ARX:  begin mr_q <= sum[47:0] + {47'd0, sum[48]}; my_q <= '0; end
               default: begin mr_q <= '0; my_q <= '0; end
            endcase
         end
      end
   end

   assign alu_done   = manual ? m_done   : (hang ? 1'b0 : md_q);
   assign alu_result = manual ? m_result : mr_q;
   assign alu_y      = manual ? m_y      : my_q;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("hs_rsp_valid_low", 64'(rsp_valid), 64'd0);
      chk("hs_cmd_ready", 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      chk("rst_alu_op", 64'(alu_op), 64'd0);
      chk("rst_alu_a", 64'(alu_a), 64'd0);
      chk("rst_acc", 64'(acc), 64'd0);
      chk("rst_y", 64'(y), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_error", 64'(rsp_error), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);

      // AND, single-cycle: response 3 edges after accept
      cmd_valid = 1'b1; cmd_op = OP_AND; cmd_a = 48'hFFFF_0000_FFFF; cmd_b = 48'h0F0F_0F0F_0F0F;
      step();
      cmd_valid = 1'b0;
      chk("and_op_c1", 64'(alu_op), 64'(OP_AND));
      chk("and_busy", 64'(busy), 64'd1);
      chk("and_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("and_alu_a", 64'(alu_a), 64'h0000_FFFF_0000_FFFF);
      step();
      chk("and_op_c2", 64'(alu_op), 64'(OP_AND));
      chk("and_rsp_early", 64'(rsp_valid), 64'd0);
      step();
      chk("and_release_nop", 64'(alu_op), 64'd0);
      chk("and_acc", 64'(acc), 64'h0000_0F0F_0000_0F0F);
      chk("and_y", 64'(y), 64'd0);
      chk("and_rsp_early2", 64'(rsp_valid), 64'd0);
      step();
      chk("and_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("and_rsp_error", 64'(rsp_error), 64'd0);
      chk("and_resp_nop", 64'(alu_op), 64'd0);
      handshake();

      // ARX, two-cycle with end-around carry: response 4 edges after accept
      cmd_valid = 1'b1; cmd_op = OP_ARX; cmd_a = 48'hFFFF_FFFF_FFFF; cmd_b = 48'h0000_0000_0002;
      step();
      cmd_valid = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk($sformatf("arx_rsp_low_%0d", i), 64'(rsp_valid), 64'd0);
      end
      step();
      chk("arx_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("arx_acc", 64'(acc), 64'h0000_0000_0000_0002);
      handshake();

      // Hung ALU: 16 ISSUE cycles, one NOP cycle, error response, acc/y kept
      hang = 1'b1;
      cmd_valid = 1'b1; cmd_op = OP_ARX; cmd_a = 48'h1234_5678_9ABC; cmd_b = 48'h1;
      step();
      cmd_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("to_issue_%0d", i), 64'(alu_op), 64'(OP_ARX));
         step();
      end
      chk("to_release_nop", 64'(alu_op), 64'd0);
      chk("to_rsp_low", 64'(rsp_valid), 64'd0);
      step();
      chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("to_rsp_error", 64'(rsp_error), 64'd1);
      chk("to_acc_kept", 64'(acc), 64'd2);
      chk("to_y_kept", 64'(y), 64'd0);
      handshake();
      hang = 1'b0;

      // Stale done in first ISSUE cycle must be ignored
      manual = 1'b1; m_done = 1'b0;
      cmd_valid = 1'b1; cmd_op = OP_XOR; cmd_a = 48'h0000_1111_2222; cmd_b = 48'h3333_0000_4444;
      step();
      cmd_valid = 1'b0;
      m_done = 1'b1; m_result = 48'hDEAD_DEAD_DEAD; m_y = 48'hBAD0_BAD0_BAD0;
      step();
      m_done = 1'b0;
      step();
      chk("stale_acc_kept", 64'(acc), 64'd2);
      chk("stale_op_held", 64'(alu_op), 64'(OP_XOR));
      m_done = 1'b1; m_result = 48'h0123_4567_89AB; m_y = 48'h0000_0000_00CD;
      step();
      m_done = 1'b0;
      chk("stale_release_nop", 64'(alu_op), 64'd0);
      chk("stale_acc", 64'(acc), 64'h0000_0123_4567_89AB);
      chk("stale_y", 64'(y), 64'h0000_0000_0000_00CD);
      step();
      chk("stale_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("stale_rsp_error", 64'(rsp_error), 64'd0);
      handshake();
      manual = 1'b0;

      // Two XOR commands with cmd_valid held high; second waits for the response handshake
      cmd_valid = 1'b1; cmd_op = OP_XOR; cmd_a = 48'hAAAA_5555_F0F0; cmd_b = 48'h0F0F_FFFF_0000;
      step();
      cmd_a = 48'h1111_2222_3333; cmd_b = 48'h4444_5555_6666;
      repeat (3) step();
      chk("xor1_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("xor1_acc", 64'(acc), 64'h0000_A5A5_AAAA_F0F0);
      chk("xor1_y", 64'(y), 64'h0000_AAAA_5555_F0F0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("xor_hold_ready_%0d", i), 64'(cmd_ready), 64'd0);
         chk($sformatf("xor_hold_a_%0d", i), 64'(alu_a), 64'h0000_AAAA_5555_F0F0);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("xor_idle_ready", 64'(cmd_ready), 64'd1);
      step();
      cmd_valid = 1'b0;
      chk("xor2_alu_a", 64'(alu_a), 64'h0000_1111_2222_3333);
      chk("xor2_busy", 64'(busy), 64'd1);
      repeat (3) step();
      chk("xor2_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("xor2_acc", 64'(acc), 64'h0000_5555_7777_5555);
      chk("xor2_y", 64'(y), 64'h0000_1111_2222_3333);
      handshake();

      // Reset in the middle of an ARX
      cmd_valid = 1'b1; cmd_op = OP_ARX; cmd_a = 48'h5; cmd_b = 48'h6;
      step();
      cmd_valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_op", 64'(alu_op), 64'd0);
      chk("mid_rst_acc", 64'(acc), 64'd0);
      chk("mid_rst_rsp", 64'(rsp_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      cmd_valid = 1'b1; cmd_op = OP_AND; cmd_a = 48'h0000_00FF_FF00; cmd_b = 48'h0000_0FF0_0FF0;
      step();
      cmd_valid = 1'b0;
      repeat (3) step();
      chk("post_rst_rsp", 64'(rsp_valid), 64'd1);
      chk("post_rst_acc", 64'(acc), 64'h0000_0000_00F0_0F00);
      chk("post_rst_err", 64'(rsp_error), 64'd0);
      handshake();

      // NOP command goes straight to a response without touching acc
      cmd_valid = 1'b1; cmd_op = OP_NOP; cmd_a = 48'h7; cmd_b = 48'h8;
      step();
      cmd_valid = 1'b0;
      chk("nop_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("nop_alu_op", 64'(alu_op), 64'd0);
      chk("nop_acc", 64'(acc), 64'h0000_0000_00F0_0F00);
      handshake();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
